// File: rtl/mips_pkg.sv
// Shared FSM state and encoding constants for the memory access unit.
// Pure declarations: no latency, no backpressure.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } mau_state_e;

    localparam logic [1:0] MW_LOAD  = 2'b00;
    localparam logic [1:0] MW_BYTE  = 2'b01;
    localparam logic [1:0] MW_WORD  = 2'b10;
    localparam logic [1:0] MW_DWORD = 2'b11;

    localparam logic [1:0] LT_WORD_S = 2'b00;
    localparam logic [1:0] LT_BYTE_S = 2'b01;
    localparam logic [1:0] LT_BYTE_Z = 2'b10;
    localparam logic [1:0] LT_WORD_Z = 2'b11;

    // Word accesses need addr[1:0]==0, doubleword accesses need addr[2:0]==0.
    function automatic logic is_misaligned(
        input logic [1:0] memwrite,
        input logic       dtype,
        input logic [1:0] ltype,
        input logic [2:0] lo
    );
        logic is_word;
        logic is_dword;
        is_word  = (memwrite == MW_WORD) ||
                   ((memwrite == MW_LOAD) && !dtype &&
                    ((ltype == LT_WORD_S) || (ltype == LT_WORD_Z)));
        is_dword = (memwrite == MW_DWORD) || ((memwrite == MW_LOAD) && dtype);
        return (is_word && (lo[1:0] != 2'b00)) || (is_dword && (lo != 3'b000));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane select/extend for loads and lane merge for stores, little-endian lanes.
// Purely combinational, zero latency, no backpressure.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  lane_i,
    input  logic [1:0]  memwrite_i,
    input  logic        dtype_i,
    input  logic [1:0]  ltype_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [31:0] word_sel;
    logic [63:0] ext;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        word_sel = lane_i[2] ? word_i[63:32] : word_i[31:0];
        ext      = 64'd0;
        case (ltype_i)
            LT_WORD_S: ext = {{32{word_sel[31]}}, word_sel};
            LT_BYTE_S: ext = {{56{byte_sel[7]}}, byte_sel};
            LT_BYTE_Z: ext = {56'd0, byte_sel};
            LT_WORD_Z: ext = {32'd0, word_sel};
            default:   ext = 64'd0;
        endcase
        load_o = dtype_i ? word_i : ext;
    end

    always_comb begin
        merge_o = word_i;
        case (memwrite_i)
            MW_BYTE: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            MW_WORD: begin
                if (lane_i[2]) merge_o[63:32] = wdata_i[31:0];
                else           merge_o[31:0]  = wdata_i[31:0];
            end
            MW_DWORD: merge_o = wdata_i;
            default:  merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: 3-cycle load/doubleword store, 4-cycle read-modify-write, stalls on mem_ack.
// Alignment faulting is built only with MEM_ALIGN_CHECK_EN defined; req is ignored while busy.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [1:0]    memwrite,
    input  logic          dtype,
    input  logic [1:0]    ltype,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    mau_state_e    state_q, state_d;
    logic [1:0]    mw_q, mw_d;
    logic          dtype_q, dtype_d;
    logic [1:0]    ltype_q, ltype_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rword_q, rword_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          fault;
    logic [DW-1:0] lane_word;
    logic [DW-1:0] lane_load;
    logic [DW-1:0] lane_merge;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb fault = is_misaligned(memwrite, dtype, ltype, addr[2:0]);
`else
    always_comb fault = 1'b0;
`endif

    // Loads extract straight from the bus; the RMW merge works on the latched word.
    assign lane_word = (state_q == ST_RD) ? mem_rdata : rword_q;

    mem_lane_align u_lane (
        .word_i     (lane_word),
        .lane_i     (addr_q[2:0]),
        .memwrite_i (mw_q),
        .dtype_i    (dtype_q),
        .ltype_i    (ltype_q),
        .wdata_i    (wdata_q),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (fault)                      state_d = ST_DONE;
                    else if (memwrite == MW_DWORD)  state_d = ST_WR;
                    else                            state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (mem_ack) state_d = (mw_q == MW_LOAD) ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                if (mem_ack) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mw_q    <= MW_LOAD;
            dtype_q <= 1'b0;
            ltype_q <= LT_WORD_S;
            addr_q  <= '0;
            wdata_q <= '0;
            rword_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            mw_q    <= mw_d;
            dtype_q <= dtype_d;
            ltype_q <= ltype_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rword_q <= rword_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        mw_d    = mw_q;
        dtype_d = dtype_q;
        ltype_d = ltype_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rword_d = rword_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    mw_d    = memwrite;
                    dtype_d = dtype;
                    ltype_d = ltype;
                    addr_d  = addr;
                    wdata_d = wdata;
                    mis_d   = fault;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    rword_d = mem_rdata;
                    if (mw_q == MW_LOAD) rdata_d = lane_load;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        misalign  = mis_q;
        mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
        mem_we    = (state_q == ST_WR);
        mem_addr  = {addr_q[AW-1:3], 3'b000};
        mem_wdata = (state_q == ST_WR) ? lane_merge : '0;
        rdata     = rdata_q;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width.
REQ-002 SHALL have parameter DW, default 64, data and memory word width; only 64 is supported.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port req, input, 1, access request pulse from the controller's memory state.
REQ-006 SHALL have port memwrite, input, 2, store size: 00 load, 01 byte, 10 word (32b), 11 doubleword.
REQ-007 SHALL have port dtype, input, 1, for loads: 1 doubleword, 0 sub-doubleword per ltype.
REQ-008 SHALL have port ltype, input, 2, sub-doubleword load: 00 word sign-ext, 01 byte sign-ext, 10 byte zero-ext, 11 word zero-ext.
REQ-009 SHALL have port addr, input, AW, byte address.
REQ-010 SHALL have port wdata, input, DW, store data, right-aligned.
REQ-011 SHALL have port rdata, output, DW, extended load result.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port misalign, output, 1, one-cycle alignment-fault pulse.
REQ-015 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, AW), mem_wdata (out, DW), mem_rdata (in, DW), mem_ack (in, 1).

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-017 SHALL capture memwrite, dtype, ltype, addr and wdata on the IDLE cycle where req=1; req outside IDLE SHALL be ignored.
REQ-018 SHALL transition IDLE->WR for a doubleword store, IDLE->RD for all loads and byte/word stores.
REQ-019 SHALL transition RD->DONE (load) or RD->WR (byte/word store, read-modify-write) on mem_ack=1, and stay in RD otherwise.
REQ-020 SHALL transition WR->DONE on mem_ack=1, and stay in WR otherwise; DONE->IDLE unconditionally.
REQ-021 SHALL assert mem_req in RD and WR, held until mem_ack; mem_we=1 only in WR; mem_addr SHALL be the captured address with bits [2:0] forced to 0.
REQ-022 SHALL use little-endian lanes: byte lane = addr[2:0], word lane = addr[2].
REQ-023 SHALL, in WR after RMW, drive mem_wdata as the latched read word with only the addressed byte/word lane replaced by wdata[7:0]/wdata[31:0].
REQ-024 SHALL latch rdata on the RD ack cycle of a load: dtype=1 gives the full word; otherwise the selected lane, extended per ltype.
REQ-025 SHALL hold rdata unchanged until the next load completes; stores SHALL NOT modify rdata.
REQ-026 SHALL assert done only in DONE (latency from req: load/RMW-free = 3 cycles with ack on the first request cycle; RMW = 4 cycles).
REQ-027 SHALL, when mem_ack arrives outside RD/WR, ignore it.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, return to IDLE from any state, abandoning any in-flight access without completing a write.
REQ-029 SHALL reset rdata to 0 and busy, done, misalign, mem_req and mem_we to 0; mem_addr/mem_wdata to 0.

Configuration
REQ-030 SHALL, with MEM_ALIGN_CHECK_EN defined, treat word access with addr[1:0]!=0 or doubleword access with addr[2:0]!=0 as a fault: IDLE->DONE, misalign=1 and done=1 in that cycle, no mem_req issued, rdata unchanged.
REQ-031 SHALL, without MEM_ALIGN_CHECK_EN, hold misalign constant 0 and ignore the sub-alignment address bits (word uses addr[2] only, doubleword none).

Structure
REQ-032 SHALL place the FSM state enum and the memwrite/ltype encoding constants in shared package mips_pkg.
REQ-033 SHALL implement lane selection/extension and store merge in one combinational sub-module, mem_lane_align.

Verification
REQ-034 SHALL cover: lb ltype=01 addr=0x1005, mem_rdata=0x0000_8000_0000_0000 -> rdata=0xFFFF_FFFF_FFFF_FF80, done 1 cycle after ack.
REQ-035 SHALL cover: sb addr=0x2003, wdata=0xAB, memory word 0x1122_3344_5566_7788 -> WR mem_wdata=0x1122_3344_AB66_7788.
REQ-036 SHALL cover: sd addr=0x3000, wdata=0xDEAD_BEEF_0123_4567, ack delayed 3 cycles -> mem_req held 4 cycles, no RD, one write.
REQ-037 SHALL cover: reset asserted in WR while mem_ack=0 -> next cycle IDLE, mem_req=0, busy=0, no done.
REQ-038 SHALL cover: MEM_ALIGN_CHECK_EN, lw addr=0x4002 -> misalign=1, done=1, mem_req never asserted.
REQ-039 SHALL cover: req asserted while busy -> ignored; lwu ltype=11 addr=0x5004, mem_rdata upper word 0x8000_0001 -> rdata=0x0000_0000_8000_0001.
